// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM command master: single-beat read/write commands in on a valid/ready
// port, driven onto the bus honouring waitrequest, with pipelined reads tracked
// by an outstanding-read counter and read data returned on a response port.
// Commands stalled for TIMEOUT waitrequest cycles are dropped and flagged.
module avalon_mm_cmd_master #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_PENDING = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_be,
    output logic [AW-1:0]   address,
    output logic            read,
    output logic            write,
    output logic [DW-1:0]   writedata,
    output logic [DW/8-1:0] byteenable,
    input  logic            waitrequest,
    input  logic [DW-1:0]   readdata,
    input  logic            readdatavalid,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            timeout_err,
    output logic [3:0]      pending,
    output logic            busy
);

    // Stall counter only needs to reach TIMEOUT
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] stall_cnt_reg;
    logic          accept;
    logic          xfer_done;
    logic          stall_abort;
    logic          read_done;
    logic          rdv_counted;

    // Reads are throttled by the outstanding count; writes never are
    assign cmd_ready   = (state_reg == IDLE) && (cmd_write || (pending < 4'(MAX_PENDING)));
    assign accept      = cmd_valid && cmd_ready;
    assign xfer_done   = (state_reg == BUS) && !waitrequest;
    assign read_done   = read && !waitrequest;
    // A readdatavalid with nothing outstanding is a stray beat and is ignored
    assign rdv_counted = readdatavalid && (pending != 4'd0);
    assign busy        = (state_reg == BUS) || (pending != 4'd0);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign stall_abort = 1'b0;
        end else begin : g_timeout
            // Abort on the stalled cycle that brings the count up to TIMEOUT
            assign stall_abort = (state_reg == BUS) && waitrequest &&
                                 (stall_cnt_reg == TW'(TIMEOUT - 1));
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: IDLE until a command is taken, BUS until it completes or aborts
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (xfer_done || stall_abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs: loaded on accept, read/write dropped when the transfer ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
        end else if (accept) begin
            address    <= cmd_addr;
            writedata  <= cmd_wdata;
            byteenable <= cmd_be;
            read       <= !cmd_write;
            write      <= cmd_write;
        end else if (xfer_done || stall_abort) begin
            read       <= 1'b0;
            write      <= 1'b0;
        end
    end

    // Counts stalled BUS cycles; restarts on every entry to BUS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (accept) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == BUS) && waitrequest) begin
            stall_cnt_reg <= stall_cnt_reg + TW'(1);
        end
    end

    // One-cycle pulse for an aborted command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= stall_abort;
        end
    end

    // Outstanding reads: up on an accepted read, down on a counted data beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 4'd0;
        end else if (read_done && !rdv_counted) begin
            pending <= pending + 4'd1;
        end else if (!read_done && rdv_counted) begin
            pending <= pending - 4'd1;
        end
    end

    // Registered read response, no backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rdv_counted;
            if (rdv_counted) begin
                rsp_data <= readdata;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Randomised bench for avalon_mm_cmd_master: a command driver, a randomly
// stalling slave with out-of-band read latency, and a scoreboard monitor
// that checks bus transfers, the outstanding count, timeouts and responses.
module tb_avalon_mm_cmd_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXP = 4;
    localparam int TMO  = 8;
    localparam int NCMD = 300;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_be;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [3:0]    byteenable;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          timeout_err;
    logic [3:0]    pending;
    logic          busy;

    avalon_mm_cmd_master #(
        .AW(AW), .DW(DW), .MAX_PENDING(MAXP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .timeout_err(timeout_err), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          cyc;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    bus_t bus_q[$];      // accepted commands, in order, awaiting the bus
    rsp_t ret_q[$];      // slave: completed reads awaiting their data beat
    rsp_t exp_rsp_q[$];  // responses expected from the DUT

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit force_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void report_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Present one command and hold it until it is accepted (bounded)
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        int  n = 0;
        bit  done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_be    = be;
        while (!done) begin
            #4;
            if (cmd_ready) begin
                bus_q.push_back('{w, a, d, be, cyc});
                $display("cmd  %s addr=%08h data=%08h be=%h accepted cycle %0d",
                         w ? "WR" : "RD", a, d, be, cyc);
                done = 1'b1;
            end else if (n >= 300) begin
                report_fail("accept_wait");
                cmd_valid = 1'b0;
                done = 1'b1;
            end else begin
                n++;
                @(negedge clk);
            end
        end
    endtask

    // Slave: random waitrequest per transfer, in-order read data after random latency
    initial begin : slave
        bit active = 1'b0;
        int stall_left = 0;
        int r;
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            @(negedge clk);
            if (ret_q.size() != 0 && ret_q[0].cyc <= cyc) begin
                readdatavalid = 1'b1;
                readdata      = ret_q[0].data;
                exp_rsp_q.push_back('{ret_q[0].data, cyc + 1});
                void'(ret_q.pop_front());
            end else if (ret_q.size() == 0 && $urandom_range(0, 15) == 0) begin
                readdatavalid = 1'b1;               // stray beat, nothing outstanding
                readdata      = $urandom;
            end else begin
                readdatavalid = 1'b0;
                readdata      = $urandom;
            end
            if (read || write) begin
                if (!active) begin
                    active = 1'b1;
                    r = $urandom_range(0, 15);
                    stall_left = (r < 8) ? 0 : (r < 14) ? $urandom_range(1, 4) : 20;
                end
                waitrequest = force_stall || (stall_left > 0);
                if (stall_left > 0) stall_left--;
                if (!waitrequest) begin
                    active = 1'b0;
                    if (read) ret_q.push_back('{$urandom, cyc + $urandom_range(1, 12)});
                end
            end else begin
                active      = 1'b0;
                waitrequest = force_stall ? 1'b1 : 1'(($urandom_range(0, 1)));
            end
        end
    end

    // Scoreboard monitor: samples one time unit before each rising edge
    initial begin : monitor
        bus_t cur;
        rsp_t e;
        bit   on_bus = 1'b0;
        bit   fresh = 1'b0;
        bit   terr_exp = 1'b0;
        int   stall = 0;
        int   pend_m = 0;
        bit   on_bus_n;
        bit   terr_n;
        int   pend_n;
        cur = '{1'b0, 32'h0, 32'h0, 4'h0, 0};
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("pending", 64'(pending), 64'(pend_m));
                chk("bus_active", 64'(read | write), 64'(on_bus));
                chk("busy", 64'(busy), 64'(on_bus || pend_m != 0));
                chk("cmd_ready", 64'(cmd_ready), 64'(!on_bus && (cmd_write || pend_m < MAXP)));
                chk("rd_wr_excl", 64'(read & write), 64'd0);
                if (timeout_err || terr_exp)
                    chk("timeout_err", 64'(timeout_err), 64'(terr_exp));

                if (rsp_valid) begin
                    if (exp_rsp_q.size() == 0) begin
                        report_fail("unexpected_rsp");
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("rsp_data", 64'(rsp_data), 64'(e.data));
                        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                        $display("rsp  data=%08h cycle %0d", rsp_data, cyc);
                    end
                end else if (exp_rsp_q.size() != 0 && exp_rsp_q[0].cyc <= cyc) begin
                    report_fail("missing_rsp");
                    void'(exp_rsp_q.pop_front());
                end

                on_bus_n = on_bus;
                terr_n   = 1'b0;
                pend_n   = pend_m;
                if (on_bus) begin
                    if (fresh) begin
                        fresh = 1'b0;
                        if (bus_q.size() == 0) begin
                            report_fail("bus_without_cmd");
                        end else begin
                            cur = bus_q.pop_front();
                            chk("start_latency", 64'(cyc), 64'(cur.cyc + 1));
                            chk("write", 64'(write), 64'(cur.w));
                            chk("read", 64'(read), 64'(!cur.w));
                            chk("address", 64'(address), 64'(cur.a));
                            chk("writedata", 64'(writedata), 64'(cur.d));
                            chk("byteenable", 64'(byteenable), 64'(cur.be));
                        end
                    end
                    if (!waitrequest) begin
                        on_bus_n = 1'b0;
                        if (!cur.w) pend_n++;
                        if (stall > 0) chk("hold_address", 64'(address), 64'(cur.a));
                        $display("bus  %s addr=%08h done after %0d stalls cycle %0d",
                                 cur.w ? "WR" : "RD", cur.a, stall, cyc);
                    end else begin
                        stall++;
                        if (stall == TMO) begin
                            on_bus_n = 1'b0;
                            terr_n   = 1'b1;
                            chk("hold_address", 64'(address), 64'(cur.a));
                            $display("bus  %s addr=%08h timed out cycle %0d",
                                     cur.w ? "WR" : "RD", cur.a, cyc);
                        end
                    end
                end else if (cmd_valid && cmd_ready) begin
                    on_bus_n = 1'b1;
                    fresh    = 1'b1;
                    stall    = 0;
                end
                if (readdatavalid && pend_m != 0) pend_n--;
                on_bus   = on_bus_n;
                terr_exp = terr_n;
                pend_m   = pend_n;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int gap;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #4;
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_writedata", 64'(writedata), 64'd0);
        chk("rst_byteenable", 64'(byteenable), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while a stalled write is on the bus
        force_stall = 1'b1;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        cmd_valid = 1'b0;
        #4;
        chk("midbus_write", 64'(write), 64'd1);
        chk("midbus_address", 64'(address), 64'h10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midbus_rst_write", 64'(write), 64'd0);
        chk("midbus_rst_pending", 64'(pending), 64'd0);
        chk("midbus_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        force_stall = 1'b0;
        #4;
        chk("midbus_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        bus_q.delete();
        @(negedge clk);
        mon_en = 1'b1;

        // Randomised traffic
        for (int i = 0; i < NCMD; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end

        // Drain
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (80) @(negedge clk);
        #4;
        chk("drain_bus_q", 64'(bus_q.size()), 64'd0);
        chk("drain_rsp_q", 64'(exp_rsp_q.size()), 64'd0);
        chk("drain_pending", 64'(pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
